// File: rtl/branch_redirect_ctrl.sv
// Redirect sequencer behind the EX branch unit. On a taken branch it flushes IF/ID,
// hands the target PC to fetch over valid/ready, drains fetch, and traps misaligned targets.
module branch_redirect_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_valid_i,
    input  logic        ex_taken_i,
    input  logic [31:0] ex_target_i,
    input  logic        redirect_ready_i,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_if_o,
    output logic        flush_id_o,
    output logic        ex_stall_o,
    output logic        misalign_exc_o,
    output logic [31:0] misalign_tval_o,
    output logic [31:0] redirect_cnt_o
);

    localparam int CW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] drain_q, drain_d;
    logic [31:0]   cnt_q;
    logic          take, misaligned, idle_take, hs;

    assign take       = ex_valid_i && ex_taken_i;
    assign misaligned = ex_target_i[1:0] != 2'b00;
    assign idle_take  = (state_q == IDLE) && take;
    assign hs         = (state_q == REDIRECT) && redirect_ready_i;

    assign redirect_cnt_o = cnt_q;

    always_comb begin
        state_d          = state_q;
        drain_d          = drain_q;
        redirect_valid_o = 1'b0;
        flush_if_o       = 1'b0;
        flush_id_o       = 1'b0;
        ex_stall_o       = 1'b0;
        case (state_q)
            IDLE: begin
                // Younger instructions die even when the target traps.
                if (take) begin
                    flush_if_o = 1'b1;
                    flush_id_o = 1'b1;
                    if (!misaligned) state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                redirect_valid_o = 1'b1;
                ex_stall_o       = 1'b1;
                flush_if_o       = 1'b1;
                flush_id_o       = 1'b1;
                if (redirect_ready_i) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                        drain_d = CW'(FLUSH_CYCLES);
                    end
                end
            end
            DRAIN: begin
                flush_if_o = 1'b1;
                drain_d    = drain_q - CW'(1);
                if (drain_q <= CW'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            drain_q         <= '0;
            redirect_pc_o   <= RESET_PC;
            misalign_exc_o  <= 1'b0;
            misalign_tval_o <= 32'h0;
            cnt_q           <= 32'h0;
        end else begin
            state_q        <= state_d;
            drain_q        <= drain_d;
            misalign_exc_o <= idle_take && misaligned;
            if (idle_take && misaligned)  misalign_tval_o <= ex_target_i;
            if (idle_take && !misaligned) redirect_pc_o   <= ex_target_i;
            if (hs)                       cnt_q           <= cnt_q + 32'd1;
        end
    end

endmodule
